spi_slave_rx_tx: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 6 +
 rtl/sync_edge.sv | 27 ++
 rtl/spi_slave_rx_tx.sv | 117 +++++++++++
 tb/tb_spi_slave_rx_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared widths and state encoding for the SPI slave front end
package spi_slave_pkg;
  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;
  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: SYNC_STAGES-deep synchroniser with a history flop for rise/fall pulses
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~hist_q;
  assign fall_o = ~q_o & hist_q;
endmodule

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: oversampled SPI mode-0 slave, bytes in on MOSI and out on MISO.
// Define SPI_SLAVE_ERR_EN to add the frame_err and underrun status pulses.
module spi_slave_rx_tx
  import spi_slave_pkg::*;
#(
  parameter int          SYNC_STAGES   = 2,
  parameter logic        IDLE_MISO     = 1'b0,
  parameter logic [7:0]  UNDERRUN_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_ss_,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_first,
  input  logic              tx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              busy
`ifdef SPI_SLAVE_ERR_EN
  ,
  output logic              frame_err,
  output logic              underrun
`endif
);
  logic sck_r, sck_f, ss_s, ss_r, ss_f, mosi_s;
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .d_i(spi_clk), .q_o(), .rise_o(sck_r), .fall_o(sck_f));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .reset(reset), .d_i(spi_ss_), .q_o(ss_s), .rise_o(ss_r), .fall_o(ss_f));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .d_i(spi_mosi), .q_o(mosi_s), .rise_o(), .fall_o());
  state_e                 state_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic                   first_q, rx_pend_q;
  logic [BYTE_W-1:0]      rx_shift_q, tx_shift_q, tx_load_d;
  logic                   sck_rise, sck_fall;
  assign sck_rise  = sck_r & ~ss_s;
  assign sck_fall  = sck_f & ~ss_s;
  assign tx_load_d = tx_valid ? tx_data : UNDERRUN_BYTE;
  assign busy      = (state_q == ST_ACTIVE);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      first_q    <= 1'b0;
      rx_pend_q  <= 1'b0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      spi_miso   <= IDLE_MISO;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_first   <= 1'b0;
      tx_ready   <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
      frame_err  <= 1'b0;
      underrun   <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      rx_pend_q <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
      frame_err <= 1'b0;
      underrun  <= 1'b0;
`endif
      // completed byte is presented one cycle after the wrapping sck_rise
      if (rx_pend_q) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_shift_q;
        rx_first <= first_q;
        first_q  <= 1'b0;
      end
      case (state_q)
        ST_IDLE: if (ss_f) begin
          state_q    <= ST_ACTIVE;
          bit_cnt_q  <= '0;
          first_q    <= 1'b1;
          tx_shift_q <= tx_load_d;
          spi_miso   <= tx_load_d[BYTE_W-1];
          tx_ready   <= tx_valid;
`ifdef SPI_SLAVE_ERR_EN
          underrun   <= ~tx_valid;
`endif
        end
        default: if (ss_r) begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
          spi_miso  <= IDLE_MISO;
`ifdef SPI_SLAVE_ERR_EN
          frame_err <= (bit_cnt_q != '0);
`endif
        end else begin
          if (sck_rise) begin
            rx_shift_q <= {rx_shift_q[BYTE_W-2:0], mosi_s};
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            rx_pend_q  <= &bit_cnt_q;
          end
          if (sck_fall && bit_cnt_q != '0) begin
            tx_shift_q <= {tx_shift_q[BYTE_W-2:0], 1'b0};
            spi_miso   <= tx_shift_q[BYTE_W-2];
          end else if (sck_fall) begin
            tx_shift_q <= tx_load_d;
            spi_miso   <= tx_load_d[BYTE_W-1];
            tx_ready   <= tx_valid;
`ifdef SPI_SLAVE_ERR_EN
            underrun   <= ~tx_valid;
`endif
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// tb_spi_slave_rx_tx: directed table, corner sequences and random transfers against a byte-level model
module tb_spi_slave_rx_tx;
  logic       clk = 0, reset = 1, spi_clk = 0, spi_ss_ = 1, spi_mosi = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic       spi_miso, rx_valid, rx_first, tx_ready, busy;
  logic [7:0] rx_data;
`ifdef SPI_SLAVE_ERR_EN
  logic       frame_err, underrun;
`endif
  always #5 clk = ~clk;
  spi_slave_rx_tx #(.SYNC_STAGES(2), .IDLE_MISO(1'b0), .UNDERRUN_BYTE(8'h00)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_ss_(spi_ss_), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .rx_valid(rx_valid), .rx_data(rx_data), .rx_first(rx_first),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy)
`ifdef SPI_SLAVE_ERR_EN
    , .frame_err(frame_err), .underrun(underrun)
`endif
  );
  int pass_cnt = 0, tot_cnt = 0;
  logic [7:0] rxq_d[$];
  logic       rxq_f[$];
  int txr_cnt, bad_txr, fe_cnt, un_cnt;
  logic [7:0] mo[4], td[4], gm[4];
  logic       tv[4];
  always @(negedge clk) begin
    if (rx_valid) begin
      rxq_d.push_back(rx_data);
      rxq_f.push_back(rx_first);
    end
    if (tx_ready) begin
      txr_cnt++;
      if (!busy) bad_txr++;
    end
`ifdef SPI_SLAVE_ERR_EN
    if (frame_err) fe_cnt++;
    if (underrun) un_cnt++;
`endif
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  // ab != 0 aborts the transfer after ab rising edges of the first byte
  task automatic xfer(input int n, input int ab);
    int total;
    total = (ab != 0) ? ab : n * 8;
    rxq_d.delete(); rxq_f.delete();
    txr_cnt = 0; bad_txr = 0; fe_cnt = 0; un_cnt = 0;
    tx_valid = tv[0]; tx_data = td[0];
    clks(2);
    spi_ss_ = 0;
    clks(8);
    chk("busy active", busy, 1);
    for (int k = 0; k < total; k++) begin
      spi_mosi = mo[k/8][7-k%8];
      clks(4);
      gm[k/8][7-k%8] = spi_miso;
      spi_clk = 1;
      clks(4);
      if (k == total - 1) begin
        spi_clk = 0;
        spi_ss_ = 1;
      end else begin
        if (k % 8 == 7) begin
          tx_valid = tv[k/8+1];
          tx_data  = td[k/8+1];
        end
        spi_clk = 0;
      end
    end
    clks(10);
    tx_valid = 0;
  endtask
  task automatic check_xfer(input string nm, input int n, input int ab);
    int nfull, loaded, ntv;
    nfull  = (ab != 0) ? 0 : n;
    loaded = (ab != 0) ? 1 : n;
    ntv    = 0;
    for (int b = 0; b < loaded; b++) ntv += int'(tv[b]);
    chk({nm, " rx count"}, rxq_d.size(), nfull);
    for (int b = 0; b < nfull; b++) begin
      if (b < rxq_d.size()) begin
        chk({nm, " rx_data"}, rxq_d[b], mo[b]);
        chk({nm, " rx_first"}, rxq_f[b], (b == 0));
      end
      chk({nm, " miso byte"}, gm[b], tv[b] ? td[b] : 8'h00);
    end
    chk({nm, " tx_ready count"}, txr_cnt, ntv);
    chk({nm, " tx_ready in idle"}, bad_txr, 0);
    chk({nm, " miso idle"}, spi_miso, 0);
    chk({nm, " busy idle"}, busy, 0);
`ifdef SPI_SLAVE_ERR_EN
    chk({nm, " frame_err count"}, fe_cnt, (ab != 0));
    chk({nm, " underrun count"}, un_cnt, loaded - ntv);
`endif
  endtask
  typedef struct {
    logic [7:0] mo;
    logic       tv;
    logic [7:0] td;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;
  vec_t tbl[5];
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{8'hA5, 1'b1, 8'h3C, 8'hA5, 8'h3C};
    tbl[1] = '{8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF};
    tbl[2] = '{8'hFF, 1'b0, 8'h77, 8'hFF, 8'h00};
    tbl[3] = '{8'h80, 1'b1, 8'h01, 8'h80, 8'h01};
    tbl[4] = '{8'h01, 1'b1, 8'h80, 8'h01, 8'h80};
    clks(3);
    chk("reset miso", spi_miso, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_first", rx_first, 0);
    chk("reset tx_ready", tx_ready, 0);
    chk("reset busy", busy, 0);
    reset = 0;
    clks(3);
    chk("post-reset busy", busy, 0);
    chk("post-reset miso", spi_miso, 0);
    for (int i = 0; i < 5; i++) begin
      mo[0] = tbl[i].mo; tv[0] = tbl[i].tv; td[0] = tbl[i].td;
      xfer(1, 0);
      check_xfer("table", 1, 0);
      chk("table rx", (rxq_d.size() > 0) ? rxq_d[0] : 8'hXX, tbl[i].exp_rx);
      chk("table miso", gm[0], tbl[i].exp_miso);
    end
    mo[0] = 8'h01; mo[1] = 8'h80; mo[2] = 8'hFF;
    tv[0] = 0; tv[1] = 0; tv[2] = 0; td[0] = 8'h11; td[1] = 8'h22; td[2] = 8'h33;
    xfer(3, 0);
    check_xfer("burst", 3, 0);
    mo[0] = 8'hFF; tv[0] = 1; td[0] = 8'h99;
    xfer(1, 5);
    check_xfer("abort", 1, 5);
    mo[0] = 8'h42; tv[0] = 1; td[0] = 8'hC3;
    xfer(1, 0);
    check_xfer("after abort", 1, 0);
    tx_valid = 1; tx_data = 8'hFF;
    clks(2);
    spi_ss_ = 0;
    clks(8);
    for (int k = 0; k < 3; k++) begin
      spi_mosi = 1;
      clks(4);
      spi_clk = 1;
      clks(4);
      spi_clk = 0;
    end
    clks(5);
    chk("pre-reset miso high", spi_miso, 1);
    reset = 1;
    #1;
    chk("mid reset miso", spi_miso, 0);
    chk("mid reset rx_data", rx_data, 0);
    chk("mid reset rx_valid", rx_valid, 0);
    chk("mid reset tx_ready", tx_ready, 0);
    chk("mid reset busy", busy, 0);
    spi_ss_ = 1; spi_clk = 0; tx_valid = 0;
    clks(3);
    reset = 0;
    clks(3);
    mo[0] = 8'h5A; tv[0] = 0; td[0] = 8'h00;
    xfer(1, 0);
    check_xfer("after reset", 1, 0);
    for (int t = 0; t < 20; t++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int b = 0; b < 4; b++) begin
        mo[b] = 8'($urandom);
        tv[b] = 1'($urandom_range(0, 1));
        td[b] = 8'($urandom);
      end
      xfer(n, 0);
      check_xfer("random", n, 0);
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
